bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter NrHosts, default 2: number of requesting hosts (2..8).
REQ-002 Parameter DataWidth, default 32: data bus width.
REQ-003 Parameter AddressWidth, default 32: address bus width.
REQ-004 Parameter MaxOutstanding, default 2: maximum accepted-but-unanswered transactions (1..8).
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk_i  in  1  system clock; all state updates on rising edge.
REQ-007 rst_ni  in  1  synchronous active-low reset.
REQ-008 host_req_i / host_we_i  in  1 [NrHosts]  per-host request, write enable.
REQ-009 host_addr_i / host_wdata_i  in  AddressWidth / DataWidth [NrHosts]  per-host address, write data.
REQ-010 host_be_i  in  DataWidth/8 [NrHosts]  per-host byte enables.
REQ-011 host_gnt_o  out  1 [NrHosts]  per-host grant, at most one bit high per cycle.
REQ-012 host_rvalid_o / host_err_o  out  1 [NrHosts]  per-host response valid, response error.
REQ-013 host_rdata_o  out  DataWidth [NrHosts]  per-host read data.
REQ-014 dev_req_o / dev_we_o / dev_addr_o / dev_be_o / dev_wdata_o  out  matching widths  shared device request channel.
REQ-015 dev_gnt_i  in  1  device accepts the current request.
REQ-016 dev_rvalid_i / dev_err_i / dev_rdata_i  in  1 / 1 / DataWidth  device response channel.
REQ-017 unexpected_rsp_o  out  1  sticky flag: dev_rvalid_i seen with no outstanding transaction.

Function
- REQ-018 Handshake: request accepted in the cycle where req and gnt are both high; the response arrives at least one cycle later, in order.
- REQ-019 Winner: the first host with host_req_i high, searching upward (wrapping NrHosts-1 -> 0) from priority pointer prio_q.
- REQ-020 dev_req_o is high iff any host requests and the outstanding count is below MaxOutstanding; dev_* request fields are a combinational mux of the winner's inputs.
- REQ-021 host_gnt_o[winner] = dev_req_o & dev_gnt_i; all other grant bits are 0. Zero added latency on the request path.
- REQ-022 On each accepted transaction, prio_q <= (winner+1) mod NrHosts; prio_q is otherwise held.
- REQ-023 On each accepted transaction the winner index is pushed into an in-order ID FIFO of depth MaxOutstanding.
- REQ-024 On dev_rvalid_i with the FIFO non-empty: the head is popped, and host_rvalid_o[head], host_err_o[head] = dev_err_i and host_rdata_o[head] = dev_rdata_i are driven in the same cycle.
- REQ-025 host_rdata_o of every host is driven with dev_rdata_i at all times; host_rvalid_o and host_err_o are 0 for non-head hosts.
- REQ-026 FIFO full: dev_req_o is forced 0 even if a pop occurs in the same cycle (no bypass).
- REQ-027 Push and pop in the same cycle (not full): the count is unchanged and FIFO order is preserved.
- REQ-028 dev_rvalid_i with the FIFO empty: no host_rvalid_o, no state change except unexpected_rsp_o <= 1.
- REQ-029 The host request fields are ignored while that host is not granted; a host may drop its request before grant without effect.
- REQ-030 Pointer and count arithmetic wraps modulo its range; the count never exceeds MaxOutstanding and never goes below 0.

Reset
- REQ-031 On rst_ni low at a clock edge: prio_q = 0, FIFO empty (count 0, read/write pointers 0), unexpected_rsp_o = 0.
- REQ-032 During reset all host_gnt_o, host_rvalid_o, host_err_o and dev_req_o are 0.
- REQ-033 Reset mid-operation discards outstanding IDs; responses arriving after reset set unexpected_rsp_o.

Structure
- REQ-034 No new shared-package typedefs; the ID width is $clog2(NrHosts) computed locally.
- REQ-035 The ID FIFO is one sub-module, bus_arb_id_fifo (params Depth, Width; push/pop/full/empty/head), with synchronous active-low reset.
- REQ-036 bus_rr_arbiter instantiates one bus_arb_id_fifo and contains the round-robin logic and response routing.

Verification
- REQ-037 Both hosts request continuously, dev_gnt_i=1, rvalid 1 cycle later -> grants alternate 0,1,0,1; each response goes to the matching host.
- REQ-038 Only host 1 requests, dev_gnt_i=1 -> host 1 is granted each cycle until 2 outstanding, then dev_req_o=0 until an rvalid arrives.
- REQ-039 MaxOutstanding=2: two accepts, then rvalid with dev_rdata_i=32'hA5A5_0001 then 32'h0000_0002 -> routed in accept order to the correct hosts.
- REQ-040 dev_rvalid_i pulse with nothing outstanding -> no host_rvalid_o; unexpected_rsp_o=1 until reset.
- REQ-041 Reset asserted with 1 outstanding, then rvalid after release -> no host response, unexpected_rsp_o=1, prio_q=0.
- REQ-042 Response with dev_err_i=1 -> host_err_o high only for the owning host, in the same cycle as its host_rvalid_o.

Source files
------------

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared helpers for the round-robin bus arbiter.
// Index arithmetic used by both the arbiter and its ID FIFO.
package bus_rr_arbiter_pkg;

   function automatic int wrap_add(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of granted host IDs awaiting a device response.
// Storage is unreset; only pointers and count are cleared.
module bus_arb_id_fifo
   import bus_rr_arbiter_pkg::*;
#(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d = PtrW'(wrap_add(int'(wr_ptr_q), 1, Depth));
      end
      if (do_pop) begin
         rd_ptr_d = PtrW'(wrap_add(int'(rd_ptr_q), 1, Depth));
      end
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one device port among several hosts.
// Responses return in order and are routed by the ID FIFO head.
module bus_rr_arbiter
   import bus_rr_arbiter_pkg::*;
#(
   parameter int unsigned NrHosts        = 2,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddressWidth   = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic [NrHosts-1:0]                      host_req_i,
   input  logic [NrHosts-1:0]                      host_we_i,
   input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
   input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
   input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
   output logic [NrHosts-1:0]                      host_gnt_o,
   output logic [NrHosts-1:0]                      host_rvalid_o,
   output logic [NrHosts-1:0]                      host_err_o,
   output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
   output logic                                    dev_req_o,
   output logic                                    dev_we_o,
   output logic [AddressWidth-1:0]                 dev_addr_o,
   output logic [DataWidth/8-1:0]                  dev_be_o,
   output logic [DataWidth-1:0]                    dev_wdata_o,
   input  logic                                    dev_gnt_i,
   input  logic                                    dev_rvalid_i,
   input  logic                                    dev_err_i,
   input  logic [DataWidth-1:0]                    dev_rdata_i,
   output logic                                    unexpected_rsp_o
);

   localparam int unsigned IdW = $clog2(NrHosts);

   logic [IdW-1:0] prio_q, prio_d;
   logic [IdW-1:0] winner;
   logic [IdW-1:0] head;
   logic           found;
   logic           full, empty;
   logic           accept, rsp_hit;
   logic           unexpected_q, unexpected_d;

   // Scan upward from the priority pointer, wrapping past the top host.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < NrHosts; i++) begin
         if (!found && host_req_i[wrap_add(int'(prio_q), i, NrHosts)]) begin
            found  = 1'b1;
            winner = IdW'(wrap_add(int'(prio_q), i, NrHosts));
         end
      end
   end

   assign dev_req_o   = rst_ni & found & ~full;
   assign dev_we_o    = host_we_i[winner];
   assign dev_addr_o  = host_addr_i[winner];
   assign dev_be_o    = host_be_i[winner];
   assign dev_wdata_o = host_wdata_i[winner];

   assign accept  = dev_req_o & dev_gnt_i;
   assign rsp_hit = rst_ni & dev_rvalid_i & ~empty;

   always_comb begin
      host_gnt_o            = '0;
      host_gnt_o[winner]    = accept;
      host_rvalid_o         = '0;
      host_rvalid_o[head]   = rsp_hit;
      host_err_o            = '0;
      host_err_o[head]      = rsp_hit & dev_err_i;
   end

   assign host_rdata_o = {NrHosts{dev_rdata_i}};

   always_comb begin
      prio_d       = prio_q;
      unexpected_d = unexpected_q | (dev_rvalid_i & empty);
      if (accept) begin
         prio_d = IdW'(wrap_add(int'(winner), 1, NrHosts));
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prio_q       <= '0;
         unexpected_q <= 1'b0;
      end else begin
         prio_q       <= prio_d;
         unexpected_q <= unexpected_d;
      end
   end

   assign unexpected_rsp_o = unexpected_q;

   bus_arb_id_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdW)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (accept),
      .data_i  (winner),
      .pop_i   (rsp_hit),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head)
   );

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: directed scenarios then random traffic.
// A queue-based model predicts grants and response routing.
module tb_bus_rr_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MO = 2;

   typedef struct {
      int          owner;
      logic        err;
      logic [31:0] data;
   } rsp_t;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [N-1:0]              host_req;
   logic [N-1:0]              host_we;
   logic [N-1:0][AW-1:0]      host_addr;
   logic [N-1:0][DW-1:0]      host_wdata;
   logic [N-1:0][DW/8-1:0]    host_be;
   logic [N-1:0]              host_gnt_o;
   logic [N-1:0]              host_rvalid_o;
   logic [N-1:0]              host_err_o;
   logic [N-1:0][DW-1:0]      host_rdata_o;
   logic                      dev_req_o, dev_we_o;
   logic [AW-1:0]             dev_addr_o;
   logic [DW/8-1:0]           dev_be_o;
   logic [DW-1:0]             dev_wdata_o;
   logic                      dev_gnt, dev_rvalid, dev_err;
   logic [DW-1:0]             dev_rdata;
   logic                      unexpected_rsp_o;

   int   tests = 0;
   int   fails = 0;
   int   q[$];
   rsp_t sb_q[$];
   int   prio_m = 0;
   logic unexp_m = 1'b0;
   logic known = 1'b0;
   logic [N-1:0] last_gnt;

   always #5 clk = ~clk;

   bus_rr_arbiter #(
      .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .host_req_i(host_req), .host_we_i(host_we),
      .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_be_i(host_be),
      .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
      .host_err_o(host_err_o), .host_rdata_o(host_rdata_o),
      .dev_req_o(dev_req_o), .dev_we_o(dev_we_o), .dev_addr_o(dev_addr_o),
      .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
      .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
      .dev_err_i(dev_err), .dev_rdata_i(dev_rdata),
      .unexpected_rsp_o(unexpected_rsp_o)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_winner(input logic [N-1:0] req);
      for (int k = 0; k < N; k++) begin
         if (req[(prio_m + k) % N]) return (prio_m + k) % N;
      end
      return -1;
   endfunction

   task automatic cycle(input logic [N-1:0] req, input logic gnt,
                        input logic rv, input logic err,
                        input logic [DW-1:0] rd, input logic rst);
      int        w;
      logic      exp_req, acc;
      logic [N-1:0] exp_gnt;
      rsp_t      e;
      @(negedge clk);
      rst_n      = rst;
      host_req   = req;
      dev_gnt    = gnt;
      dev_rvalid = rv;
      dev_err    = err;
      dev_rdata  = rd;
      for (int h = 0; h < N; h++) begin
         host_we[h]    = 1'($urandom);
         host_addr[h]  = $urandom;
         host_wdata[h] = $urandom;
         host_be[h]    = 4'($urandom);
      end
      #1;
      w       = model_winner(req);
      exp_req = rst && (w >= 0) && (q.size() < MO);
      acc     = exp_req && gnt;
      exp_gnt = '0;
      if (acc) exp_gnt[w] = 1'b1;
      chk("dev_req", 64'(dev_req_o), 64'(exp_req));
      chk("host_gnt", 64'(host_gnt_o), 64'(exp_gnt));
      if (exp_req) begin
         chk("dev_addr", 64'(dev_addr_o), 64'(host_addr[w]));
         chk("dev_we", 64'(dev_we_o), 64'(host_we[w]));
         chk("dev_be", 64'(dev_be_o), 64'(host_be[w]));
         chk("dev_wdata", 64'(dev_wdata_o), 64'(host_wdata[w]));
      end
      for (int h = 0; h < N; h++) chk("rdata_bcast", 64'(host_rdata_o[h]), 64'(rd));
      if (known) chk("unexpected", 64'(unexpected_rsp_o), 64'(unexp_m));
      last_gnt = host_gnt_o;
      if (!rst) begin
         q.delete();
         prio_m  = 0;
         unexp_m = 1'b0;
         known   = 1'b1;
      end else begin
         if (rv) begin
            if (q.size() > 0) begin
               e.owner = q.pop_front();
               e.err   = err;
               e.data  = rd;
               sb_q.push_back(e);
            end else begin
               unexp_m = 1'b1;
            end
         end
         if (acc) begin
            q.push_back(w);
            prio_m = (w + 1) % N;
         end
      end
   endtask

   task automatic drain();
      while (q.size() > 0) cycle('0, 1'b0, 1'b1, 1'b0, $urandom, 1'b1);
   endtask

   // Response monitor: every presented response must match the oldest expectation.
   always @(negedge clk) begin
      rsp_t e;
      #2;
      if (host_rvalid_o != '0) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_rvalid: got %b expected none", host_rvalid_o);
         end else begin
            e = sb_q.pop_front();
            chk("rsp_owner", 64'(host_rvalid_o), 64'(1) << e.owner);
            chk("rsp_err", 64'(host_err_o), e.err ? (64'(1) << e.owner) : 64'(0));
            chk("rsp_data", 64'(host_rdata_o[e.owner]), 64'(e.data));
         end
      end else begin
         chk("idle_err", 64'(host_err_o), 64'(0));
      end
   end

   initial begin
      rst_n = 1'b0; host_req = '0; dev_gnt = 1'b0;
      dev_rvalid = 1'b0; dev_err = 1'b0; dev_rdata = '0;
      host_we = '0; host_addr = '0; host_wdata = '0; host_be = '0;

      cycle('0, 1'b1, 1'b1, 1'b0, $urandom, 1'b0);
      cycle(2'b11, 1'b1, 1'b0, 1'b0, $urandom, 1'b0);
      chk("reset_gnt", 64'(last_gnt), 64'(0));

      // Alternating grants with one-cycle responses
      for (int i = 0; i < 8; i++) begin
         cycle(2'b11, 1'b1, q.size() > 0, 1'b0, $urandom, 1'b1);
         chk("alt_gnt", 64'(last_gnt), (i % 2) ? 64'd2 : 64'd1);
      end
      drain();

      // Single host fills the outstanding limit
      for (int i = 0; i < 4; i++) begin
         cycle(2'b10, 1'b1, 1'b0, 1'b0, $urandom, 1'b1);
         chk("solo_gnt", 64'(last_gnt), (i < 2) ? 64'd2 : 64'd0);
      end
      cycle(2'b10, 1'b1, 1'b1, 1'b0, $urandom, 1'b1);
      chk("full_no_bypass", 64'(last_gnt), 64'd0);
      cycle(2'b10, 1'b1, 1'b0, 1'b0, $urandom, 1'b1);
      chk("refill_gnt", 64'(last_gnt), 64'd2);
      drain();

      // Two accepts, responses in accept order
      cycle(2'b11, 1'b1, 1'b0, 1'b0, $urandom, 1'b1);
      cycle(2'b11, 1'b1, 1'b0, 1'b0, $urandom, 1'b1);
      cycle('0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001, 1'b1);
      cycle('0, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 1'b1);

      // Response with nothing outstanding is sticky
      cycle('0, 1'b0, 1'b1, 1'b0, $urandom, 1'b1);
      repeat (3) cycle('0, 1'b0, 1'b0, 1'b0, $urandom, 1'b1);
      chk("unexp_sticky", 64'(unexpected_rsp_o), 64'd1);

      // Reset with one outstanding, late response is unexpected
      cycle('0, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);
      chk("unexp_cleared", 64'(unexpected_rsp_o), 64'd1);
      cycle(2'b01, 1'b1, 1'b0, 1'b0, $urandom, 1'b1);
      chk("unexp_after_rst", 64'(unexpected_rsp_o), 64'd0);
      cycle('0, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);
      cycle('0, 1'b0, 1'b1, 1'b0, $urandom, 1'b1);
      cycle(2'b11, 1'b1, 1'b0, 1'b0, $urandom, 1'b1);
      chk("post_rst_prio", 64'(last_gnt), 64'd1);
      chk("post_rst_unexp", 64'(unexpected_rsp_o), 64'd1);
      drain();

      // Error response routed only to its owner
      cycle(2'b10, 1'b1, 1'b0, 1'b0, $urandom, 1'b1);
      cycle(2'b01, 1'b1, 1'b0, 1'b0, $urandom, 1'b1);
      cycle('0, 1'b0, 1'b1, 1'b1, $urandom, 1'b1);
      cycle('0, 1'b0, 1'b1, 1'b0, $urandom, 1'b1);

      repeat (1500) begin
         cycle(N'($urandom), ($urandom % 4) != 0,
               (q.size() > 0) ? 1'($urandom) : (($urandom % 20) == 0),
               ($urandom % 4) == 0, $urandom, ($urandom % 150) != 0);
      end

      cycle('0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      #3;
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
